// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency-meter datapath
// (edge detector, gate controller, divider, display formatter).
package freq_meter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {IDLE, ARM, GATE, HOLD} gate_state_t;

endpackage

// File: rtl/freq_gate_timer.sv
// Cycle counter with clear/enable; compares the next count against the
// gate length and the abort limit. Serves both the ARM wait and the GATE count.
module freq_gate_timer
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_next,
    output logic             gate_hit,
    output logic             timeout_hit
);

    localparam logic [CNT_W-1:0] GateLim    = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // Compares look at the value this cycle would produce, so a limit is
    // acted on in the same cycle the count reaches it.
    always_comb begin
        cnt_next    = cnt_q + CNT_W'(1);
        gate_hit    = (cnt_next >= GateLim);
        timeout_hit = (cnt_next == TimeoutLim);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_next;
        end
    end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Reciprocal-count measurement window: arm, open on a signal edge, count
// signal edges and reference clocks, close on an edge, hand off the result.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter int unsigned GATE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             sig_edge,
    output logic             busy,
    output logic             gate_open,
    output logic [CNT_W-1:0] sig_cnt,
    output logic [CNT_W-1:0] ref_cnt,
    output logic             timeout,
    output logic             res_valid,
    input  logic             res_ready
);

    gate_state_t      state_q, state_d;
    logic [CNT_W-1:0] s_q, s_d;
    logic             tmr_clr, tmr_en;
    logic [CNT_W-1:0] r_next;
    logic             gate_hit, timeout_hit;
    logic             latch;
    logic [CNT_W-1:0] lat_s, lat_r;
    logic             lat_to;

    freq_gate_timer #(
        .CNT_W         (CNT_W),
        .GATE_CYCLES   (GATE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr        (tmr_clr),
        .en         (tmr_en),
        .cnt_next   (r_next),
        .gate_hit   (gate_hit),
        .timeout_hit(timeout_hit)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        latch   = 1'b0;
        lat_s   = '0;
        lat_r   = '0;
        lat_to  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ARM;
            end
            ARM: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                if (sig_edge) begin
                    state_d = GATE;
                    tmr_clr = 1'b1;
                    s_d     = '0;
                end else if (timeout_hit) begin
                    state_d = HOLD;
                    latch   = 1'b1;
                    lat_to  = 1'b1;
                end
            end
            GATE: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                s_d     = s_q + CNT_W'(sig_edge);
                // A closing edge takes priority over the abort limit.
                if (sig_edge && gate_hit) begin
                    state_d = HOLD;
                    latch   = 1'b1;
                    lat_s   = s_d;
                    lat_r   = r_next;
                end else if (timeout_hit) begin
                    state_d = HOLD;
                    latch   = 1'b1;
                    lat_s   = s_d;
                    lat_r   = r_next;
                    lat_to  = 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) state_d = cont_mode ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            busy      <= 1'b0;
            gate_open <= 1'b0;
            res_valid <= 1'b0;
            sig_cnt   <= '0;
            ref_cnt   <= '0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            busy      <= (state_d != IDLE);
            gate_open <= (state_d == GATE);
            res_valid <= (state_d == HOLD);
            if (latch) begin
                sig_cnt <= lat_s;
                ref_cnt <= lat_r;
                timeout <= lat_to;
            end
        end
    end

endmodule
